sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed-threshold 16x8 FIFO. It adds run-time programmable almost-full and almost-empty thresholds, a first-word-fall-through (FWFT) mode, synchronous flush, and saturating overflow/underflow event counters. It sits between producer and consumer in the same clock domain and exposes the existing status set: wr_ack, full, empty, almostfull, almostempty, overflow, underflow and count.

---
 rtl/sync_fifo_prog.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through, synchronous flush and error counters.
module sync_fifo_prog #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic                            flush,
    input  logic [$clog2(FIFO_DEPTH):0]     af_level,
    input  logic [$clog2(FIFO_DEPTH):0]     ae_level,
    input  logic                            clr_err,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic [ERR_CNT_W-1:0]            ovf_cnt,
    output logic [ERR_CNT_W-1:0]            udf_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [ERR_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [ERR_CNT_W-1:0] udf_cnt_q, udf_cnt_d;

    logic wr_acc, rd_acc, ovf_evt, udf_evt;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_level) && !full;
    assign almostempty = (count_q <= ae_level) && !empty;

    // Flush masks both requests, so it neither moves pointers nor raises events.
    always_comb begin
        rd_acc  = rd_en && !empty && !flush;
        wr_acc  = wr_en && (!full || rd_acc) && !flush;
        ovf_evt = wr_en && !wr_acc && !flush;
        udf_evt = rd_en && !rd_acc && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc)
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (rd_acc)
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            if (wr_acc && !rd_acc)
                count_d = count_q + CNT_W'(1);
            else if (rd_acc && !wr_acc)
                count_d = count_q - CNT_W'(1);
        end

        wr_ack_d    = wr_acc;
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;

        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (clr_err) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (ovf_evt && (ovf_cnt_q != '1))
                ovf_cnt_d = ovf_cnt_q + ERR_CNT_W'(1);
            if (udf_evt && (udf_cnt_q != '1))
                udf_cnt_d = udf_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ovf_cnt_q   <= '0;
            udf_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
            udf_cnt_q   <= udf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= mem_q[rd_ptr_q];
            end
            assign data_out = dout_q;
        end
    endgenerate

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign udf_cnt   = udf_cnt_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: one standard-mode and one FWFT instance,
// expectations queued per cycle by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_sync_fifo_prog;

    localparam int W = 16;
    localparam int D = 8;
    localparam int CW = 4;

    localparam int S_DOUT = 0, S_WACK = 1, S_OVF = 2, S_UDF = 3, S_FULL = 4, S_EMPTY = 5,
                   S_AF = 6, S_AE = 7, S_CNT = 8, S_OVFC = 9, S_UDFC = 10,
                   F_DOUT = 11, F_WACK = 12, F_EMPTY = 13, F_CNT = 14, F_UDFC = 15, F_UDF = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [W-1:0]  s_din, f_din;
    logic          s_wr, s_rd, s_flush, s_clr, f_wr, f_rd, f_flush, f_clr;
    logic [CW-1:0] s_af, s_ae, f_af, f_ae;
    logic [W-1:0]  s_dout, f_dout;
    logic          s_wack, s_ovf, s_udf, s_full, s_empty, s_afl, s_ael;
    logic          f_wack, f_ovf, f_udf, f_full, f_empty, f_afl, f_ael;
    logic [CW-1:0] s_cnt, f_cnt;
    logic [7:0]    s_ovfc, s_udfc, f_ovfc, f_udfc;

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0), .ERR_CNT_W(8)) u_std (
        .clk(clk), .rst_n(rst_n), .data_in(s_din), .wr_en(s_wr), .rd_en(s_rd),
        .flush(s_flush), .af_level(s_af), .ae_level(s_ae), .clr_err(s_clr),
        .data_out(s_dout), .wr_ack(s_wack), .overflow(s_ovf), .underflow(s_udf),
        .full(s_full), .empty(s_empty), .almostfull(s_afl), .almostempty(s_ael),
        .count(s_cnt), .ovf_cnt(s_ovfc), .udf_cnt(s_udfc));

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1), .ERR_CNT_W(8)) u_fwft (
        .clk(clk), .rst_n(rst_n), .data_in(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .flush(f_flush), .af_level(f_af), .ae_level(f_ae), .clr_err(f_clr),
        .data_out(f_dout), .wr_ack(f_wack), .overflow(f_ovf), .underflow(f_udf),
        .full(f_full), .empty(f_empty), .almostfull(f_afl), .almostempty(f_ael),
        .count(f_cnt), .ovf_cnt(f_ovfc), .udf_cnt(f_udfc));

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int sel);
        case (sel)
            S_DOUT:  get = 32'(s_dout);
            S_WACK:  get = 32'(s_wack);
            S_OVF:   get = 32'(s_ovf);
            S_UDF:   get = 32'(s_udf);
            S_FULL:  get = 32'(s_full);
            S_EMPTY: get = 32'(s_empty);
            S_AF:    get = 32'(s_afl);
            S_AE:    get = 32'(s_ael);
            S_CNT:   get = 32'(s_cnt);
            S_OVFC:  get = 32'(s_ovfc);
            S_UDFC:  get = 32'(s_udfc);
            F_DOUT:  get = 32'(f_dout);
            F_WACK:  get = 32'(f_wack);
            F_EMPTY: get = 32'(f_empty);
            F_CNT:   get = 32'(f_cnt);
            F_UDFC:  get = 32'(f_udfc);
            F_UDF:   get = 32'(f_udf);
            default: get = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compares every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = get(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    // Expectation on an output value after the next rising edge.
    task automatic push(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.sel = sel; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic s_idle;
        s_wr = 0; s_rd = 0; s_flush = 0; s_clr = 0;
    endtask

    task automatic f_idle;
        f_wr = 0; f_rd = 0; f_flush = 0; f_clr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        s_idle(); f_idle();
        s_din = '0; f_din = '0;
        s_af = 4'd7; s_ae = 4'd1; f_af = 4'd7; f_ae = 4'd1;
        step(); step();
        rst_n = 1;

        // Reset then idle
        push(S_CNT, 0, "rst_count"); push(S_EMPTY, 1, "rst_empty"); push(S_FULL, 0, "rst_full");
        push(S_AF, 0, "rst_af"); push(S_AE, 0, "rst_ae"); push(S_WACK, 0, "rst_wack");
        push(S_OVFC, 0, "rst_ovfc"); push(S_DOUT, 0, "rst_dout");
        push(F_DOUT, 0, "f_rst_dout"); push(F_EMPTY, 1, "f_rst_empty");
        step();

        // Fill from empty
        for (int i = 0; i < 8; i++) begin
            s_wr = 1; s_din = W'(16'hA000 + i);
            push(S_WACK, 1, "fill_wack"); push(S_CNT, 32'(i + 1), "fill_count");
            push(S_AE, (i == 0) ? 1 : 0, "fill_ae"); push(S_AF, (i == 6) ? 1 : 0, "fill_af");
            push(S_FULL, (i == 7) ? 1 : 0, "fill_full");
            step();
        end
        s_din = 16'hA0FF;
        push(S_OVF, 1, "ovf_flag"); push(S_WACK, 0, "ovf_wack");
        push(S_OVFC, 1, "ovf_cnt"); push(S_CNT, 8, "ovf_count");
        step();
        s_idle();

        // Drain in standard mode
        for (int i = 0; i < 8; i++) begin
            s_rd = 1;
            push(S_DOUT, 32'(16'hA000 + i), "drain_data"); push(S_CNT, 32'(7 - i), "drain_count");
            push(S_UDF, 0, "drain_udf");
            step();
        end
        push(S_UDF, 1, "udf_flag"); push(S_UDFC, 1, "udf_cnt");
        push(S_DOUT, 16'hA007, "udf_hold"); push(S_EMPTY, 1, "udf_empty");
        step();
        s_idle();

        // Simultaneous read/write while full, then drain across the wrap
        for (int i = 0; i < 8; i++) begin
            s_wr = 1; s_din = W'(16'hB000 + i);
            step();
        end
        s_wr = 1; s_rd = 1; s_din = 16'hC000;
        push(S_CNT, 8, "rw_full_count"); push(S_WACK, 1, "rw_full_wack");
        push(S_OVF, 0, "rw_full_ovf"); push(S_DOUT, 16'hB000, "rw_full_data");
        step();
        s_idle();
        for (int i = 1; i < 9; i++) begin
            s_rd = 1;
            push(S_DOUT, (i == 8) ? 32'hC000 : 32'(16'hB000 + i), "wrap_data");
            step();
        end
        s_idle();
        push(S_EMPTY, 1, "wrap_empty");
        step();

        // Simultaneous read/write while empty
        s_wr = 1; s_rd = 1; s_din = 16'hD000;
        push(S_CNT, 1, "rw_empty_count"); push(S_UDF, 1, "rw_empty_udf");
        push(S_WACK, 1, "rw_empty_wack"); push(S_UDFC, 2, "rw_empty_udfc");
        step();
        s_idle(); s_rd = 1;
        push(S_DOUT, 16'hD000, "rw_empty_data"); push(S_CNT, 0, "rw_empty_drain");
        step();
        s_idle();

        // Programmable thresholds af=5, ae=3
        s_af = 4'd5; s_ae = 4'd3;
        for (int n = 1; n <= 5; n++) begin
            s_wr = 1; s_din = W'(16'hE000 + n - 1);
            push(S_CNT, 32'(n), "thr_count");
            push(S_AF, (n >= 5) ? 1 : 0, "thr_af"); push(S_AE, (n <= 3) ? 1 : 0, "thr_ae");
            step();
        end
        s_idle(); s_rd = 1;
        push(S_CNT, 4, "thr_rd_count"); push(S_AF, 0, "thr_rd_af4"); push(S_AE, 0, "thr_rd_ae4");
        step();
        push(S_CNT, 3, "thr_rd_count3"); push(S_AE, 1, "thr_rd_ae3");
        step();
        s_idle();

        // Flush with a concurrent write
        s_flush = 1; s_wr = 1; s_din = 16'hF00F;
        push(S_CNT, 0, "flush_count"); push(S_EMPTY, 1, "flush_empty"); push(S_WACK, 0, "flush_wack");
        push(S_DOUT, 16'hE001, "flush_dout_hold"); push(S_OVFC, 1, "flush_ovfc");
        step();
        s_idle();

        // FWFT: fall-through and pop
        f_wr = 1; f_din = 16'h1234;
        push(F_DOUT, 16'h1234, "fwft_fall"); push(F_CNT, 1, "fwft_count");
        step();
        f_idle();
        push(F_DOUT, 16'h1234, "fwft_hold");
        step();
        f_flush = 1; f_wr = 1; f_din = 16'h5555;
        push(F_CNT, 0, "fwft_flush_count"); push(F_EMPTY, 1, "fwft_flush_empty");
        push(F_WACK, 0, "fwft_flush_wack"); push(F_DOUT, 0, "fwft_flush_dout");
        step();
        f_idle();
        f_wr = 1; f_din = 16'h0001;
        step();
        f_din = 16'h0002;
        push(F_DOUT, 16'h0001, "fwft_head");
        step();
        f_idle(); f_rd = 1;
        push(F_DOUT, 16'h0002, "fwft_pop"); push(F_CNT, 1, "fwft_pop_count");
        step();
        push(F_DOUT, 0, "fwft_empty_dout"); push(F_EMPTY, 1, "fwft_empty");
        step();

        // 300 underflows saturate the counter, clr_err wins over a same-cycle event
        for (int i = 0; i < 300; i++) begin
            f_rd = 1;
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299) begin
                push(F_UDFC, (i >= 254) ? 255 : 32'(i + 1), "udf_sat");
                push(F_UDF, 1, "udf_sat_flag");
            end
            step();
        end
        f_clr = 1; f_rd = 1;
        push(F_UDFC, 0, "clr_err_event");
        step();
        f_idle();
        push(F_UDFC, 0, "clr_err_hold"); push(F_UDF, 0, "clr_err_udf");
        step();

        step();
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
